gcd_controller: RTL

Control FSM for the 16-bit subtract-based GCD datapath. Drives its register loads and mux selects (ldA, ldB, sel1, sel2, sel_in) and consumes its comparator flags (gt, lt, eq). Provides a start/busy/done/err handshake and operand request strobes to the upstream source. Includes a watchdog that bounds the number of subtractions.

---
 rtl/gcd_pkg.sv | 21 ++
 rtl/gcd_iter_counter.sv | 28 ++
 rtl/gcd_controller.sv | 127 ++++++++++++
 3 files changed

// File: rtl/gcd_pkg.sv
// Shared encodings for the subtract-based GCD controller: FSM state codes and
// datapath mux select values.
package gcd_pkg;

  typedef logic [2:0] gcd_state_t;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD_A = 3'd1;
  localparam logic [2:0] LOAD_B = 3'd2;
  localparam logic [2:0] CHECK  = 3'd3;
  localparam logic [2:0] SUB_A  = 3'd4;
  localparam logic [2:0] SUB_B  = 3'd5;
  localparam logic [2:0] DONE   = 3'd6;
  localparam logic [2:0] ERR    = 3'd7;

  localparam logic SEL_A   = 1'b0;
  localparam logic SEL_B   = 1'b1;
  localparam logic BUS_SUB = 1'b0;
  localparam logic BUS_IN  = 1'b1;

endpackage

// File: rtl/gcd_iter_counter.sv
// Subtraction counter for the GCD watchdog: clears at the start of a run,
// counts each subtraction and flags when the limit has been reached.
module gcd_iter_counter #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned MAX_ITER = 'hFFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             at_max
);

  localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(MAX_ITER);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CNT_W'(1);
    end
  end

  // The controller tests at_max before every increment, so count never wraps.
  assign at_max = (count == MAX_VAL);

endmodule

// File: rtl/gcd_controller.sv
// Control FSM for the 16-bit subtract-based GCD datapath, with a start/busy/
// done/err handshake, operand request strobes and a subtraction watchdog.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD_A | capture operand A from data_in, clear iteration counter
// LOAD_B | capture operand B from data_in
// CHECK  | evaluate comparator flags, choose next action
// SUB_A  | A <= A - B, count one subtraction
// SUB_B  | B <= B - A, count one subtraction
// DONE   | one-cycle done pulse, result in register A
// ERR    | one-cycle err pulse, run aborted
module gcd_controller
  import gcd_pkg::*;
#(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned MAX_ITER = 'hFFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             gt,
  input  logic             lt,
  input  logic             eq,
  output logic             ldA,
  output logic             ldB,
  output logic             sel1,
  output logic             sel2,
  output logic             sel_in,
  output logic             req_a,
  output logic             req_b,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] iter_count
);

  gcd_state_t state;
  gcd_state_t state_nxt;
  logic       at_max;
  logic       cnt_clr;
  logic       cnt_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD_A;
      LOAD_A:  state_nxt = LOAD_B;
      LOAD_B:  state_nxt = CHECK;
      CHECK: begin
        // A broken comparator must never be mistaken for a valid result.
        if (!$onehot({gt, lt, eq})) state_nxt = ERR;
        else if (eq)                state_nxt = DONE;
        else if (at_max)            state_nxt = ERR;
        else if (gt)                state_nxt = SUB_A;
        else                        state_nxt = SUB_B;
      end
      SUB_A:   state_nxt = CHECK;
      SUB_B:   state_nxt = CHECK;
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ldA    = 1'b0;
    ldB    = 1'b0;
    sel1   = SEL_A;
    sel2   = SEL_A;
    sel_in = BUS_SUB;
    req_a  = 1'b0;
    req_b  = 1'b0;
    busy   = (state != IDLE);
    done   = 1'b0;
    err    = 1'b0;
    case (state)
      LOAD_A: begin
        sel_in = BUS_IN;
        ldA    = 1'b1;
        req_a  = 1'b1;
      end
      LOAD_B: begin
        sel_in = BUS_IN;
        ldB    = 1'b1;
        req_b  = 1'b1;
      end
      SUB_A: begin
        sel1 = SEL_A;
        sel2 = SEL_B;
        ldA  = 1'b1;
      end
      SUB_B: begin
        sel1 = SEL_B;
        sel2 = SEL_A;
        ldB  = 1'b1;
      end
      DONE:    done = 1'b1;
      ERR:     err  = 1'b1;
      default: ;
    endcase
  end

  assign cnt_clr = (state == LOAD_A);
  assign cnt_inc = (state == SUB_A) || (state == SUB_B);

  gcd_iter_counter #(
    .CNT_W    (CNT_W),
    .MAX_ITER (MAX_ITER)
  ) u_iter_counter (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .count  (iter_count),
    .at_max (at_max)
  );

endmodule
